// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control front-end: FSM state codes, the
// default debounce length and the registered output bundle.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;

  // 10 ms at 100 MHz
  localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

  typedef struct packed {
    logic init_regs;
    logic count_enabled;
    logic running;
    logic paused;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_OUT_RESET = '{
    init_regs:     1'b1,
    count_enabled: 1'b0,
    running:       1'b0,
    paused:        1'b0
  };

  // A single-cycle debounce still needs a one-bit counter to stay legal.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  // Unreachable code 2'd3 decodes like IDLE; the FSM also steers it back there.
  function automatic ctrl_out_t decode_state(input logic [1:0] state);
    ctrl_out_t out;
    out = CTRL_OUT_RESET;
    case (state)
      ST_RUNNING: begin
        out.init_regs     = 1'b0;
        out.count_enabled = 1'b1;
        out.running       = 1'b1;
      end
      ST_PAUSED: begin
        out.init_regs = 1'b0;
        out.paused    = 1'b1;
      end
      default: out = CTRL_OUT_RESET;
    endcase
    return out;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, counter debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CntW = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // The counter only survives while the synchronised level keeps disagreeing
  // with stable, so any bounce back restarts the qualification window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced start/stop and clear presses into
// registered init_regs / count_enabled levels for the BCD timer.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_clear,
  output logic init_regs,
  output logic count_enabled,
  output logic running,
  output logic paused
);

  logic       press_start;
  logic       press_clear;
  logic [1:0] state_q, state_d;
  ctrl_out_t  out_q, out_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_start_stop),
    .press  (press_start)
  );

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_clear (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_clear),
    .press  (press_clear)
  );

  // Clear has priority; a coincident start pulse is dropped, not deferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (press_clear)      state_d = ST_IDLE;
        else if (press_start) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (press_clear)      state_d = ST_IDLE;
        else if (press_start) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (press_clear)      state_d = ST_IDLE;
        else if (press_start) state_d = ST_RUNNING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next state into flops so they move on the same
  // edge as the state and never glitch.
  assign out_d = decode_state(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= CTRL_OUT_RESET;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign init_regs     = out_q.init_regs;
  assign count_enabled = out_q.count_enabled;
  assign running       = out_q.running;
  assign paused        = out_q.paused;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DB_CYCLES=4: directed scenarios
// plus random button activity, compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int unsigned DB = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_start_stop = 1'b0;
  logic btn_clear = 1'b0;
  logic init_regs, count_enabled, running, paused;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DB_CYCLES(DB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .running       (running),
    .paused        (paused)
  );

  // Reference model: per button, the raw level seen two edges ago must differ
  // from the accepted level for DB consecutive edges before it is accepted.
  int m_state;
  bit m_ps, m_pc;
  bit m_stable [2];
  int m_run [2];
  bit qa [$];
  bit qb [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_ps = 1'b0;
    m_pc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_stable[i] = 1'b0;
      m_run[i] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic deb(input int i, input bit level, output bit pulse);
    pulse = 1'b0;
    if (level == m_stable[i]) begin
      m_run[i] = 0;
    end else begin
      m_run[i]++;
      if (m_run[i] == DB) begin
        m_stable[i] = level;
        m_run[i] = 0;
        pulse = level;
      end
    end
  endtask

  task automatic model_step(input bit a, input bit b);
    bit sa, sb;
    if (m_pc) m_state = M_IDLE;
    else if (m_ps) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
    qa.push_back(a);
    qb.push_back(b);
    sa = (qa.size() >= 3) ? qa[qa.size() - 3] : 1'b0;
    sb = (qb.size() >= 3) ? qb[qb.size() - 3] : 1'b0;
    if (qa.size() > 3) void'(qa.pop_front());
    if (qb.size() > 3) void'(qb.pop_front());
    deb(0, sa, m_ps);
    deb(1, sb, m_pc);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".init"},    init_regs,     m_state == M_IDLE);
    check_eq({tag, ".cnt_en"},  count_enabled, m_state == M_RUN);
    check_eq({tag, ".running"}, running,       m_state == M_RUN);
    check_eq({tag, ".paused"},  paused,        m_state == M_PAUSE);
  endtask

  // Called at a negedge; drives buttons, lets one active edge pass, checks.
  task automatic tick(input string tag, input bit ss, input bit cl);
    btn_start_stop = ss;
    btn_clear = cl;
    @(posedge clk);
    model_step(ss, cl);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic hold(input string tag, input bit ss, input bit cl, input int n);
    for (int k = 0; k < n; k++) tick(tag, ss, cl);
  endtask

  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, ".init"},    init_regs,     1);
    check_eq({tag, ".cnt_en"},  count_enabled, 0);
    check_eq({tag, ".running"}, running,       0);
    check_eq({tag, ".paused"},  paused,        0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first;
    int changes;
    logic prev_ce;

    model_reset();
    repeat (3) @(negedge clk);
    check_eq("por.init",    init_regs,     1);
    check_eq("por.cnt_en",  count_enabled, 0);
    check_eq("por.running", running,       0);
    check_eq("por.paused",  paused,        0);
    rst_n = 1'b1;

    hold("idle", 1'b0, 1'b0, 20);
    check_eq("idle.init_held", init_regs, 1);

    // Toggle every 2 cycles: never stable for DB cycles.
    for (int k = 0; k < 10; k++) hold("bounce", k[0] == 1'b0, 1'b0, 2);
    hold("bounce_tail", 1'b0, 1'b0, 8);
    check_eq("bounce.init", init_regs, 1);

    first = -1;
    changes = 0;
    prev_ce = count_enabled;
    for (int j = 0; j < 10; j++) begin
      tick("start", 1'b1, 1'b0);
      if (first < 0 && count_enabled === 1'b1) first = j;
      if (count_enabled !== prev_ce) changes++;
      prev_ce = count_enabled;
    end
    check_eq("start.latency", first, 6);
    check_eq("start.one_transition", changes, 1);
    check_eq("start.running", running, 1);
    hold("start_rel", 1'b0, 1'b0, 8);

    hold("pause", 1'b1, 1'b0, 8);
    check_eq("pause.cnt_en", count_enabled, 0);
    check_eq("pause.paused", paused, 1);
    check_eq("pause.init",   init_regs, 0);
    hold("pause_rel", 1'b0, 1'b0, 8);
    hold("resume", 1'b1, 1'b0, 8);
    check_eq("resume.cnt_en", count_enabled, 1);
    check_eq("resume.init",   init_regs, 0);
    hold("resume_rel", 1'b0, 1'b0, 8);

    hold("clr_run", 1'b0, 1'b1, 8);
    check_eq("clr_run.init",   init_regs, 1);
    check_eq("clr_run.cnt_en", count_enabled, 0);
    hold("clr_run_rel", 1'b0, 1'b0, 8);

    hold("go", 1'b1, 1'b0, 8);
    hold("go_rel", 1'b0, 1'b0, 8);
    hold("go_pause", 1'b1, 1'b0, 8);
    hold("go_pause_rel", 1'b0, 1'b0, 8);
    check_eq("pre_clr.paused", paused, 1);
    hold("clr_pause", 1'b0, 1'b1, 8);
    check_eq("clr_pause.init",   init_regs, 1);
    check_eq("clr_pause.paused", paused, 0);
    hold("clr_pause_rel", 1'b0, 1'b0, 8);

    hold("go2", 1'b1, 1'b0, 8);
    hold("go2_rel", 1'b0, 1'b0, 8);
    check_eq("pre_both.running", running, 1);
    hold("both", 1'b1, 1'b1, 8);
    hold("both_rel", 1'b0, 1'b0, 12);
    check_eq("both.init",    init_regs, 1);
    check_eq("both.running", running, 0);
    check_eq("both.paused",  paused, 0);

    // Async reset from RUNNING, then a button held through reset release.
    hold("go3", 1'b1, 1'b0, 8);
    hold("go3_rel", 1'b0, 1'b0, 8);
    reset_mid("rst_run");
    hold("rst_run_idle", 1'b0, 1'b0, 4);
    hold("held_pre", 1'b1, 1'b0, 2);
    reset_mid("rst_held");
    hold("held_post", 1'b1, 1'b0, 10);
    check_eq("held.running", running, 1);
    hold("held_rel", 1'b0, 1'b0, 8);

    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 29) == 0) reset_mid("rand_rst");
      hold("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           int'($urandom_range(1, 9)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
